// File: rtl/digit_seek_driver.sv
// Seek driver for a decade counter: plans the shortest step sequence to a target digit
// and issues one command per cycle. Define DOUBLE_STEP_EN to enable +2 forward steps.
module digit_seek_driver (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Target,
  output logic       w1,
  output logic       w0,
  output logic [3:0] Tracked,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

`ifdef DOUBLE_STEP_EN
  localparam logic [3:0] BACK_MIN = 4'd7;
  localparam logic       FWD2     = 1'b1;
`else
  localparam logic [3:0] BACK_MIN = 4'd6;
  localparam logic       FWD2     = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAN, STEP, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] tgt, rem, rem_nxt, trk_nxt, d, size;
  logic [4:0] diff;
  logic       back, back_nxt;
  logic [1:0] cmd, cmd_nxt;
  logic       busy_nxt, done_nxt, err_nxt, accept;

  assign cmd    = {w1, w0};
  assign accept = (state == IDLE) && Start && (Target <= 4'd9);

  // Distance forward from Tracked to the latched target, mod 10
  always_comb begin
    diff = {1'b0, tgt} - {1'b0, Tracked};
    d    = diff[4] ? 4'(diff + 5'd10) : diff[3:0];
  end

  always_comb begin
    case (cmd)
      2'b01:   size = 4'd1;
      2'b10:   size = 4'd2;
      2'b11:   size = 4'd1;
      default: size = 4'd0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      tgt     <= 4'd0;
      rem     <= 4'd0;
      back    <= 1'b0;
      w1      <= 1'b0;
      w0      <= 1'b0;
      Tracked <= 4'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      back    <= back_nxt;
      w1      <= cmd_nxt[1];
      w0      <= cmd_nxt[0];
      Tracked <= trk_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
      Error   <= err_nxt;
      if (accept) tgt <= Target;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    back_nxt  = back;
    case (state)
      IDLE: if (accept) state_nxt = PLAN;
      PLAN: begin
        if (d == 4'd0) state_nxt = DONE;
        else begin
          back_nxt  = (d >= BACK_MIN);
          rem_nxt   = back_nxt ? 4'd10 - d : d;
          state_nxt = STEP;
        end
      end
      STEP: begin
        rem_nxt = rem - size;
        if (rem_nxt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the command is chosen one edge ahead
  always_comb begin
    cmd_nxt = 2'b00;
    if (state_nxt == STEP) begin
      if (back_nxt)                         cmd_nxt = 2'b11;
      else if (FWD2 && rem_nxt >= 4'd2)     cmd_nxt = 2'b10;
      else                                  cmd_nxt = 2'b01;
    end
    trk_nxt = Tracked;
    if (state == STEP) begin
      case (cmd)
        2'b01:   trk_nxt = (Tracked == 4'd9) ? 4'd0 : Tracked + 4'd1;
        2'b10:   trk_nxt = (Tracked >= 4'd8) ? Tracked - 4'd8 : Tracked + 4'd2;
        2'b11:   trk_nxt = (Tracked == 4'd0) ? 4'd9 : Tracked - 4'd1;
        default: trk_nxt = Tracked;
      endcase
    end
    busy_nxt = (state_nxt == PLAN) || (state_nxt == STEP);
    done_nxt = (state_nxt == DONE);
    err_nxt  = (state == IDLE) && Start && (Target > 4'd9);
  end

endmodule

// File: tb/tb_digit_seek_driver.sv
// Randomized bench for digit_seek_driver against a digit-distance reference model.
module tb_digit_seek_driver;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Target = 4'd0;
  logic       w1, w0, Busy, Done, Error;
  logic [3:0] Tracked;

  int total = 0;
  int bad   = 0;
  int mtrk  = 0;
  int cmdq[$];

  digit_seek_driver dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Target(Target),
    .w1(w1), .w0(w0), .Tracked(Tracked), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int wexp, input int bexp,
                         input int dexp, input int eexp, input int texp);
    chk({tag, ".w"}, {w1, w0}, wexp);
    chk({tag, ".busy"}, Busy, bexp);
    chk({tag, ".done"}, Done, dexp);
    chk({tag, ".err"}, Error, eexp);
    chk({tag, ".trk"}, Tracked, texp);
  endtask

  // Reference: shortest path on the 10-digit ring, commands 1=+1, 2=+2, 3=-1
  task automatic plan(input int cur, input int tgt);
    int d, r, back_min;
    bit fwd2;
`ifdef DOUBLE_STEP_EN
    back_min = 7; fwd2 = 1'b1;
`else
    back_min = 6; fwd2 = 1'b0;
`endif
    cmdq.delete();
    d = (tgt - cur + 10) % 10;
    if (d == 0) return;
    if (d >= back_min) begin
      repeat (10 - d) cmdq.push_back(3);
    end else begin
      r = d;
      while (r > 0) begin
        if (fwd2 && r >= 2) begin cmdq.push_back(2); r -= 2; end
        else begin cmdq.push_back(1); r -= 1; end
      end
    end
  endtask

  task automatic seek(input int tgt, input bit junk);
    @(negedge Clock);
    Start = 1'b1; Target = 4'(tgt);
    @(posedge Clock); #1;
    Start = 1'b0;
    if (tgt > 9) begin
      chk_all("err", 0, 0, 0, 1, mtrk);
      @(posedge Clock); #1;
      chk_all("err_after", 0, 0, 0, 0, mtrk);
      return;
    end
    chk_all("plan", 0, 1, 0, 0, mtrk);
    plan(mtrk, tgt);
    foreach (cmdq[i]) begin
      if (junk) begin Start = 1'($urandom); Target = 4'($urandom); end
      @(posedge Clock); #1;
      chk_all("step", cmdq[i], 1, 0, 0, mtrk);
      mtrk = (mtrk + (cmdq[i] == 3 ? 9 : cmdq[i])) % 10;
    end
    @(posedge Clock); #1;
    chk_all("done", 0, 0, 1, 0, tgt);
    Start = 1'b0;
    @(posedge Clock); #1;
    chk_all("idle", 0, 0, 0, 0, tgt);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b1; Target = 4'd3;
    repeat (2) @(posedge Clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    Reset = 1'b1; Start = 1'b0;
    mtrk = 0;
  endtask

  initial begin
    do_reset();
`ifdef DOUBLE_STEP_EN
    seek(3, 1'b0);
    seek(1, 1'b0);
    seek(1, 1'b0);
`else
    seek(3, 1'b0);
    seek(9, 1'b0);
    seek(9, 1'b0);
`endif
    seek(12, 1'b0);
    // Reset in the second STEP cycle of a 0 -> 5 seek
    do_reset();
    @(negedge Clock);
    Start = 1'b1; Target = 4'd5;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk_all("mid_plan", 0, 1, 0, 0, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    @(posedge Clock); #1;
    chk_all("mid_idle", 0, 0, 0, 0, 0);
    mtrk = 0;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge Clock);
      seek($urandom_range(0, 11), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_seek_driver.md
DIGIT_SEEK_DRIVER -- requirements
Module: digit_seek_driver

Interface
REQ-001 The module SHALL have port Clock, input, 1 bit: rising-edge clock for all state.
REQ-002 The module SHALL have port Reset, input, 1 bit: reset Reset, synchronous, active-low; clock Clock.
REQ-003 The module SHALL have port Start, input, 1 bit: seek request, sampled only in IDLE.
REQ-004 The module SHALL have port Target, input, 4 bits: requested digit, valid range 0-9.
REQ-005 The module SHALL have ports w1 and w0, outputs, 1 bit each: step command to the decade counter (00 hold, 01 +1, 10 +2, 11 -1).
REQ-006 The module SHALL have port Tracked, output, 4 bits: shadow copy of the counter value, range 0-9.
REQ-007 The module SHALL have port Busy, output, 1 bit: high in PLAN and STEP.
REQ-008 The module SHALL have port Done, output, 1 bit: one-cycle pulse when a seek completes.
REQ-009 The module SHALL have port Error, output, 1 bit: one-cycle pulse when Target is greater than 9.

Function
REQ-010 The FSM SHALL use states IDLE, PLAN, STEP and DONE.
REQ-011 In IDLE with Start=1, the FSM SHALL latch Target and go to PLAN if Target<=9; otherwise it SHALL pulse Error on the next cycle and stay in IDLE.
REQ-012 PLAN SHALL compute d=(Target-Tracked) mod 10 in one cycle: d=0 goes to DONE; d in 7..9 sets direction backward, remaining=10-d; else direction forward, remaining=d; then go to STEP.
REQ-013 STEP forward SHALL emit 10 while remaining>=2 and 01 when remaining=1; backward SHALL emit 11 per cycle; exactly one command is issued per cycle.
REQ-014 On each STEP edge, Tracked SHALL update mod 10 by the issued command (wrap 9->0, 0->9, 8->0, 9->1), and remaining SHALL decrease by the step size.
REQ-015 When remaining reaches 0, the FSM SHALL go to DONE; DONE SHALL assert Done for one cycle, with Tracked==latched Target, and return to IDLE.
REQ-016 w1w0 SHALL be 00 in every state other than STEP.
REQ-017 Latency: Start sampled at edge N gives PLAN in cycle N+1, k commands in cycles N+2..N+1+k, and Done in cycle N+2+k.
REQ-018 Start and Target SHALL be ignored outside IDLE; back-to-back seeks SHALL be accepted on the cycle after DONE.
REQ-019 Outputs SHALL be registered, with no combinational path from Start or Target.

Reset
REQ-020 When Reset=0 at a rising Clock edge, the module SHALL go to IDLE with Tracked=0, w1w0=00, and Busy, Done and Error all 0, regardless of state.
REQ-021 A reset mid-seek SHALL abandon the seek without a Done pulse; Tracked=0 matches the counter, which shares the same Reset.

Configuration
REQ-022 With macro DOUBLE_STEP_EN defined, the module SHALL implement the +2 forward stepping of REQ-013 and the direction rule of REQ-012 (backward for d 7..9).
REQ-023 Without DOUBLE_STEP_EN, the module SHALL use only 01 forward and 11 backward commands, go backward for d 6..9 and forward for d 1..5 (tie at d=5 goes forward), and never emit 10.

Verification
REQ-024 The bench SHALL check: Reset, then Start with Target=3 (DOUBLE_STEP_EN) -> w1w0 10 then 01, Done 4 cycles after Start, Tracked=3.
REQ-025 The bench SHALL check: from Tracked=3, Target=1 -> d=8, backward, w1w0 11,11, Tracked goes 2 then 1, Done.
REQ-026 The bench SHALL check: from Tracked=1, Target=1 -> no commands, Done 2 cycles after Start, Busy high 1 cycle.
REQ-027 The bench SHALL check: Target=12 -> Error pulse 1 cycle, w1w0 stays 00, Tracked unchanged, no Done.
REQ-028 The bench SHALL check: from Tracked=0, Target=5, Reset=0 in the second STEP cycle -> next cycle IDLE, Tracked=0, w1w0=00, no Done.
REQ-029 The bench SHALL check: without DOUBLE_STEP_EN, from Tracked=0, Target=3 -> 01,01,01; from Tracked=3, Target=9 (d=6) -> 11 four times, Tracked ends at 9.
